// File: rtl/game_life_ctrl.sv
// Game-state controller for the sprite renderer. It tracks character visibility,
// robot lives, score and the missile fire/flight/cooldown cycle. Collision events
// and the fire button act only on their rising edges. All timers count game ticks.
//
// Handshake note: this block has no valid/ready channels. Every output is a
// registered level. A collision edge seen at clock edge t shows up in the outputs
// right after edge t.
module game_life_ctrl #(
    parameter int RESPAWN_TICKS  = 32,
    parameter int FLY_TICKS      = 40,
    parameter int COOLDOWN_TICKS = 16,
    parameter int INVULN_TICKS   = 24,
    parameter int LIVES          = 3
) (
    input  logic       clk_25Hz,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    input  logic       fire,
    input  logic [3:0] Event,
    output logic       d_valid,
    output logic       d1_valid,
    output logic       d2_valid,
    output logic       r_valid,
    output logic       m_valid,
    output logic [1:0] lives,
    output logic [7:0] score,
    output logic [1:0] game_state,
    output logic       fire_ready
);

    typedef enum logic [1:0] {G_IDLE = 2'd0, G_PLAY = 2'd1, G_HIT = 2'd2, G_OVER = 2'd3} game_t;
    typedef enum logic [1:0] {M_READY = 2'd0, M_FLY = 2'd1, M_COOL = 2'd2} missile_t;

    game_t           g_q, g_d;
    missile_t        m_q, m_d;
    logic [3:0]      event_q;
    logic            fire_q;
    logic [2:0]      dv_q, dv_d;          // {d, d1, d2}
    logic            rv_q, rv_d;
    logic            mv_q, mv_d;
    logic [1:0]      lives_q, lives_d;
    logic [7:0]      score_q, score_d;
    logic [2:0][7:0] resp_q, resp_d;      // index 2 = d, 1 = d1, 0 = d2
    logic [7:0]      inv_q, inv_d;
    logic [7:0]      mcnt_q, mcnt_d;

    logic [3:0] ev_new;
    logic       fire_pe;
    logic       active;
    logic [2:0] kill;
    logic       missile_kill;
    logic [1:0] kill_cnt;
    logic [8:0] score_sum;
    logic       start_game;
    logic       robot_hit;
    logic       go_over;

    assign ev_new       = Event & ~event_q;
    assign fire_pe      = fire & ~fire_q;
    assign active       = (g_q == G_PLAY) || (g_q == G_HIT);
    assign kill         = ev_new[3:1] & dv_q & {3{active}};
    // A dragon hit in the same cycle as a robot collision was rammed, not shot.
    assign missile_kill = (|kill) && !ev_new[0];
    assign kill_cnt     = {1'b0, kill[0]} + {1'b0, kill[1]} + {1'b0, kill[2]};
    assign score_sum    = {1'b0, score_q} + {7'b0, kill_cnt};
    assign start_game   = start && ((g_q == G_IDLE) || (g_q == G_OVER));
    assign robot_hit    = (g_q == G_PLAY) && ev_new[0];
    assign go_over      = robot_hit && (lives_q == 2'd1);

    // Game FSM next state plus lives, score and dragon respawn bookkeeping
    always_comb begin
        g_d     = g_q;
        dv_d    = dv_q;
        rv_d    = rv_q;
        lives_d = lives_q;
        score_d = score_q;
        resp_d  = resp_q;
        inv_d   = inv_q;
        if (active) begin
            for (int i = 0; i < 3; i++) begin
                if (kill[i]) begin
                    // A kill beats a respawn expiry in the same cycle.
                    dv_d[i]   = 1'b0;
                    resp_d[i] = 8'(RESPAWN_TICKS);
                end else if (tick && resp_q[i] != 8'd0) begin
                    resp_d[i] = resp_q[i] - 8'd1;
                    if (resp_q[i] == 8'd1) dv_d[i] = 1'b1;
                end
            end
            if (missile_kill) score_d = score_sum[8] ? 8'hff : score_sum[7:0];
        end
        case (g_q)
            G_PLAY: begin
                if (robot_hit) begin
                    lives_d = lives_q - 2'd1;
                    if (go_over) begin
                        g_d  = G_OVER;
                        dv_d = 3'b000;
                        rv_d = 1'b0;
                    end else begin
                        g_d   = G_HIT;
                        inv_d = 8'(INVULN_TICKS);
                    end
                end
            end
            G_HIT: begin
                if (tick && inv_q != 8'd0) begin
                    inv_d = inv_q - 8'd1;
                    if (inv_q == 8'd1) g_d = G_PLAY;
                end
            end
            default: begin
                if (start_game) begin
                    g_d     = G_PLAY;
                    lives_d = 2'(LIVES);
                    score_d = 8'd0;
                    dv_d    = 3'b111;
                    rv_d    = 1'b1;
                    resp_d  = '0;
                    inv_d   = 8'd0;
                end
            end
        endcase
    end

    // Missile FSM next state; forced back to READY on game start and game over
    always_comb begin
        m_d    = m_q;
        mv_d   = mv_q;
        mcnt_d = mcnt_q;
        if (start_game || go_over) begin
            m_d    = M_READY;
            mv_d   = 1'b0;
            mcnt_d = 8'd0;
        end else if (active) begin
            case (m_q)
                M_READY: begin
                    if (fire_pe) begin
                        m_d    = M_FLY;
                        mv_d   = 1'b1;
                        mcnt_d = 8'(FLY_TICKS);
                    end
                end
                M_FLY: begin
                    // Kill and flight expiry together still make one transition.
                    if (missile_kill || (tick && mcnt_q <= 8'd1)) begin
                        m_d    = M_COOL;
                        mv_d   = 1'b0;
                        mcnt_d = 8'(COOLDOWN_TICKS);
                    end else if (tick) begin
                        mcnt_d = mcnt_q - 8'd1;
                    end
                end
                default: begin
                    if (tick) begin
                        if (mcnt_q <= 8'd1) begin
                            m_d    = M_READY;
                            mcnt_d = 8'd0;
                        end else begin
                            mcnt_d = mcnt_q - 8'd1;
                        end
                    end
                end
            endcase
        end
    end

    // State and edge registers with synchronous reset
    always_ff @(posedge clk_25Hz) begin
        if (rst) begin
            g_q     <= G_IDLE;
            m_q     <= M_READY;
            event_q <= 4'd0;
            fire_q  <= 1'b0;
            dv_q    <= 3'b000;
            rv_q    <= 1'b0;
            mv_q    <= 1'b0;
            lives_q <= 2'd0;
            score_q <= 8'd0;
            resp_q  <= '0;
            inv_q   <= 8'd0;
            mcnt_q  <= 8'd0;
        end else begin
            g_q     <= g_d;
            m_q     <= m_d;
            event_q <= Event;
            fire_q  <= fire;
            dv_q    <= dv_d;
            rv_q    <= rv_d;
            mv_q    <= mv_d;
            lives_q <= lives_d;
            score_q <= score_d;
            resp_q  <= resp_d;
            inv_q   <= inv_d;
            mcnt_q  <= mcnt_d;
        end
    end

    assign d_valid    = dv_q[2];
    assign d1_valid   = dv_q[1];
    assign d2_valid   = dv_q[0];
    assign r_valid    = rv_q;
    assign m_valid    = mv_q;
    assign lives      = lives_q;
    assign score      = score_q;
    assign game_state = g_q;
    assign fire_ready = (m_q == M_READY);

endmodule
